// File: rtl/poly_reduce_ctrl.sv
// rtl/poly_reduce_ctrl.sv - load/reduce sequencer for the shift-register polynomial reduction datapath
module poly_reduce_ctrl #(
    parameter int WIDTH  = 4,
    parameter int DEGREE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             coef_valid,
    output logic             coef_ready,
    input  logic [WIDTH-1:0] coef_data,
    output logic             dp_en,
    output logic             dp_sel,
    output logic [WIDTH-1:0] dp_data,
    input  logic [WIDTH-1:0] dp_res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data
);

    localparam int CNT_W = $clog2(DEGREE + 2);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DEGREE);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DEGREE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_CAPT,
        S_OUT,
        S_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               err_q, err_d;

    logic               load_beat;
    logic               out_hs;

    assign load_beat = (state_q == S_LOAD) && coef_valid;
    assign out_hs    = (state_q == S_OUT) && res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        // A start request is only legal from IDLE; anything else is flagged and dropped.
        err_d       = err_q | (start && (state_q != S_IDLE));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (load_beat) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_STEP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_STEP: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                res_data_d  = dp_res;
                res_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_hs) begin
                    res_valid_d = 1'b0;
                    cnt_d       = cnt_q + 1'b1;
                    state_d     = (cnt_q == LAST_STEP) ? S_FIN : S_STEP;
                end
            end
            S_FIN: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_FIN);
        coef_ready = (state_q == S_LOAD);
        dp_en      = load_beat || (state_q == S_STEP);
        dp_sel     = (state_q == S_STEP);
        dp_data    = (state_q == S_LOAD) ? coef_data : '0;
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_poly_reduce_ctrl.sv
// tb/tb_poly_reduce_ctrl.sv - scoreboard bench for poly_reduce_ctrl with a behavioural datapath
module tb_poly_reduce_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic       coef_valid;
    logic       coef_ready;
    logic [3:0] coef_data;
    logic       dp_en;
    logic       dp_sel;
    logic [3:0] dp_data;
    logic [3:0] dp_res;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int load_pulses = 0;
    int step_pulses = 0;
    int done_cnt = 0;
    logic [3:0] exp_q[$];
    int hs_times[$];
    logic [3:0] taps[4];

    poly_reduce_ctrl #(.WIDTH(4), .DEGREE(3)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .dp_en(dp_en), .dp_sel(dp_sel), .dp_data(dp_data), .dp_res(dp_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: taps[0] is the oldest coefficient; a reduce step emits head minus tail
    // and shifts toward the head, filling the tail with zero.
    initial begin
        for (int i = 0; i < 4; i++) taps[i] = '0;
        dp_res = '0;
    end

    always @(posedge clk) begin
        if (dp_en && !dp_sel) begin
            taps[0] <= taps[1];
            taps[1] <= taps[2];
            taps[2] <= taps[3];
            taps[3] <= dp_data;
        end else if (dp_en && dp_sel) begin
            dp_res  <= taps[0] - taps[3];
            taps[0] <= taps[1];
            taps[1] <= taps[2];
            taps[2] <= taps[3];
            taps[3] <= '0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("res_unexpected", 1, 0);
                end else begin
                    check("res_data", res_data, exp_q.pop_front());
                end
                hs_times.push_back(cyc);
            end
            if (dp_en && !dp_sel) load_pulses++;
            if (dp_en && dp_sel) step_pulses++;
            if (done) done_cnt++;
            if (coef_ready) check("dp_en_align", dp_en, coef_valid);
            if (!dp_en) check("dp_sel_idle", dp_sel, 0);
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("coef_ready_latency", coef_ready, 1);
    endtask

    task automatic feed(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                        input logic [3:0] c3, input logic [15:0] mask, input int mlen,
                        input bit pulse_start);
        logic [3:0] c[4];
        int idx;
        int n;
        logic rdy;
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        idx = 0;
        n = 0;
        while (idx < 4 && n < 100) begin
            coef_valid = (n < mlen) ? mask[n] : 1'b1;
            coef_data  = coef_valid ? c[idx] : 4'hA;
            if (n == 0) start = pulse_start;
            @(negedge clk);
            rdy = coef_ready;
            @(posedge clk); #1;
            if (coef_valid && rdy) idx++;
            start = 1'b0;
            n++;
        end
        coef_valid = 1'b0;
        coef_data  = '0;
        check("feed_complete", idx, 4);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        check("done_seen", done, 1);
        check("busy_in_fin", busy, 1);
    endtask

    task automatic wait_res_valid();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 100);
        check("res_valid_seen", res_valid, 1);
    endtask

    initial begin
        int l0, s0, d0;
        rst = 1'b1; start = 1'b0; coef_valid = 1'b0; coef_data = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_coef_ready", coef_ready, 0);
        check("rst_dp_en", dp_en, 0);
        check("rst_dp_data", dp_data, 0);

        // basic job
        exp_q.push_back(4); exp_q.push_back(2); exp_q.push_back(7);
        hs_times.delete();
        l0 = load_pulses; s0 = step_pulses; d0 = done_cnt;
        do_start();
        feed(4'd5, 4'd2, 4'd7, 4'd1, 16'hFFFF, 4, 1'b0);
        check("t1_step_en", dp_en, 1);
        check("t1_step_sel", dp_sel, 1);
        check("t1_loads", load_pulses - l0, 4);
        check("t1_no_early_step", step_pulses - s0, 0);
        @(posedge clk); #1;
        check("t1_capt_res_valid", res_valid, 0);
        @(posedge clk); #1;
        check("t1_first_res_valid", res_valid, 1);
        check("t1_first_res_data", res_data, 4);
        wait_done();
        @(negedge clk);
        check("t1_busy_after_fin", busy, 0);
        check("t1_done_low", done, 0);
        check("t1_steps", step_pulses - s0, 3);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_hs_count", hs_times.size(), 3);
        if (hs_times.size() == 3) begin
            check("t1_spacing_a", hs_times[1] - hs_times[0], 3);
            check("t1_spacing_b", hs_times[2] - hs_times[1], 3);
        end

        // load stalls
        exp_q.push_back(4); exp_q.push_back(2); exp_q.push_back(7);
        l0 = load_pulses; s0 = step_pulses;
        do_start();
        feed(4'd5, 4'd2, 4'd7, 4'd1, 16'b1011001, 7, 1'b0);
        check("t2_loads", load_pulses - l0, 4);
        check("t2_no_early_step", step_pulses - s0, 0);
        check("t2_step_sel", dp_sel, 1);
        wait_done();
        @(negedge clk);
        check("t2_queue_empty", exp_q.size(), 0);

        // output backpressure
        res_ready = 1'b0;
        exp_q.push_back(4); exp_q.push_back(2); exp_q.push_back(7);
        do_start();
        feed(4'd5, 4'd2, 4'd7, 4'd1, 16'hFFFF, 4, 1'b0);
        wait_res_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", res_valid, 1);
            check("t3_hold_data", res_data, 4);
            check("t3_frozen", dp_en, 0);
        end
        res_ready = 1'b1;
        wait_done();
        @(negedge clk);
        check("t3_queue_empty", exp_q.size(), 0);

        // start while busy, in LOAD and in FIN
        exp_q.push_back(4); exp_q.push_back(2); exp_q.push_back(7);
        d0 = done_cnt;
        do_start();
        feed(4'd5, 4'd2, 4'd7, 4'd1, 16'hFFFF, 4, 1'b1);
        check("t4_err_load", err, 1);
        wait_done();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_fin_start_ignored", busy, 0);
        check("t4_err_fin", err, 1);
        check("t4_done_low", done, 0);
        check("t4_queue_empty", exp_q.size(), 0);
        exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(3);
        do_start();
        feed(4'd3, 4'd3, 4'd3, 4'd3, 16'hFFFF, 4, 1'b0);
        wait_done();
        @(negedge clk);
        check("t4_fresh_queue_empty", exp_q.size(), 0);
        check("t4_err_sticky", err, 1);
        check("t4_done_count", done_cnt - d0, 2);

        // reset mid-job while a result is pending
        res_ready = 1'b0;
        exp_q.push_back(4);
        do_start();
        feed(4'd5, 4'd2, 4'd7, 4'd1, 16'hFFFF, 4, 1'b0);
        wait_res_valid();
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        res_ready = 1'b1;
        check("t5_res_valid", res_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_err", err, 0);
        check("t5_coef_ready", coef_ready, 0);
        repeat (3) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 0);

        // back-to-back jobs, including a wrapping difference
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        do_start();
        feed(4'd15, 4'd0, 4'd0, 4'd15, 16'hFFFF, 4, 1'b0);
        wait_done();
        @(posedge clk); #1;
        exp_q.push_back(13); exp_q.push_back(2); exp_q.push_back(3);
        do_start();
        feed(4'd1, 4'd2, 4'd3, 4'd4, 16'hFFFF, 4, 1'b0);
        wait_done();
        @(negedge clk);
        check("t6_queue_empty", exp_q.size(), 0);
        check("t6_err_clear", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/poly_reduce_ctrl.md
Name: poly_reduce_ctrl

Overview:
Sequencer for the shift-register polynomial reduction datapath. It accepts a coefficient stream through a valid/ready handshake and steers the datapath through a load phase and then a reduce phase by driving its select and enable. It captures each reduction result and presents it on a backpressured output stream. It sits between the coefficient source and the reduction datapath, and it is the only block that drives the datapath's select.

Parameters:
WIDTH, 4, coefficient/result width in bits (must be ≥1).
DEGREE, 3, polynomial degree; the datapath holds DEGREE+1 taps (must be ≥1).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request to begin a reduction job; ignored unless state is IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a job completes
err  out  1  sticky; set when start is asserted while busy; cleared only by rst
coef_valid  in  1  coefficient stream valid
coef_ready  out  1  coefficient stream ready
coef_data  in  WIDTH  coefficient value
dp_en  out  1  datapath clock enable for this cycle
dp_sel  out  1  datapath select: 0 = shift-in/load, 1 = reduce step
dp_data  out  WIDTH  coefficient forwarded to datapath input
dp_res  in  WIDTH  datapath result register; valid the cycle after a reduce step
res_valid  out  1  result stream valid
res_ready  in  1  result stream ready
res_data  out  WIDTH  captured reduction result

Behaviour:
- FSM states: IDLE, LOAD, STEP, CAPT, OUT, FIN. Counter cnt has width clog2(DEGREE+2).
- Reset (rst=1 at a clk edge): state=IDLE, cnt=0, res_valid=0, res_data=0, done=0, err=0. busy, coef_ready, dp_en, dp_sel and dp_data are combinational and read 0 in IDLE.
- rst mid-job: abort in the same edge with no done pulse. Any pending result is dropped, and the datapath is not flushed.
- IDLE: start=1 -> LOAD, cnt=0.
- LOAD:
  - coef_ready=1, dp_sel=0, dp_data=coef_data.
  - dp_en = coef_valid; it is combinational in the same cycle as the handshake.
  - On each accepted beat, cnt++.
  - When the (DEGREE+1)th beat is accepted -> STEP with cnt=0.
  - coef_valid gaps stall the load with no datapath activity.
- STEP: dp_en=1, dp_sel=1 for exactly one cycle -> CAPT.
- CAPT: res_data <= dp_res, res_valid <= 1 -> OUT. The result is registered one cycle after the step.
- OUT:
  - res_valid and res_data are held stable until res_ready=1.
  - On handshake: res_valid <= 0, cnt++.
  - If cnt was DEGREE-1 -> FIN; otherwise -> STEP.
  - While res_ready=0: dp_en=0 and the datapath is frozen (backpressure).
- FIN: done=1 for one cycle, cnt=0 -> IDLE. busy is still 1 during FIN.
- Job size: DEGREE+1 load beats and DEGREE reduce steps, producing DEGREE results.
- Latency with no stalls:
  - start to first coef_ready is 1 cycle.
  - Last load beat to first res_valid is 2 cycles (STEP, CAPT).
  - Result-to-result spacing is 3 cycles when res_ready is tied high.
- coef_ready=0 in every state except LOAD. Beats offered outside LOAD are not consumed.
- dp_en=0 in IDLE, CAPT, OUT and FIN. dp_sel=0 whenever dp_en=0.
- start while busy: ignored, and err <= 1. A start in the same cycle as the done pulse (FIN) also sets err. A start in IDLE on the cycle after FIN is accepted.
- No arithmetic is done in this block. res_data is a raw copy of the WIDTH-bit dp_res, and wrap-around is the datapath's concern.

Test Plan:
1. Basic job (WIDTH=4, DEGREE=3): rst, then start. Send coefficients 5, 2, 7, 1 back-to-back against a datapath model -> dp_en/dp_sel=0 for 4 cycles, then three STEP pulses with dp_sel=1. res_data = 5-1=4, then 2-0=2, then 7-0=7, each with res_valid for one handshake. done pulses once and busy falls the cycle after.
2. Load stalls: coef_valid toggling 1,0,0,1,1,0,1 -> exactly 4 dp_en pulses with dp_sel=0, aligned to the valid beats. STEP is not entered until the 4th beat.
3. Output backpressure: res_ready held 0 for 5 cycles at the first result -> res_valid=1 and res_data=4 stay stable, and no dp_en during the stall. The remaining results follow normally after release.
4. start during job: pulse start in LOAD and in FIN -> job completes unaffected and err=1 stays set. A start in IDLE afterwards runs a fresh job.
5. Reset mid-operation: assert rst in OUT with res_valid=1 -> next cycle res_valid=0, busy=0, done=0, err=0, coef_ready=0.
6. Back-to-back jobs: start in the first IDLE cycle after done with coefficients 15, 0, 0, 15 -> res_data=0, and wrap cases from the model pass through unmodified.
